if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised successor to the single-entry IF/ID pipeline register. It buffers up to `DEPTH` fetched instructions between the fetch stage and the decode stage, so fetch keeps running while decode is stalled. It keeps the existing stall, flush and bubble semantics, flags misaligned fetch addresses, and optionally byte-swaps instruction words. It sits between the PC/instruction-memory interface and `id`, and is driven by the `ctrl` stall vector and flush.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, minimum 2.
- `ADDR_W`, 32: PC width.
- `DATA_W`, 32: instruction width; multiple of 8.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset (`RstEnable`).
- `stall`  in  6  ctrl stall vector; bit 2 = decode stop (`Stop`).
- `flush`  in  1  pipeline flush (exception/eret).
- `if_valid`  in  1  fetch presents a word this cycle.
- `if_pc`  in  ADDR_W  PC of the fetched word.
- `if_inst`  in  DATA_W  raw fetched word.
- `if_ready`  out  1  queue can accept; combinational, equals `!full`.
- `id_valid`  out  1  `id_pc`/`id_inst` hold a real instruction.
- `id_pc`  out  ADDR_W  PC to decode.
- `id_inst`  out  DATA_W  instruction to decode.
- `id_adel`  out  1  fetch address error: `id_pc[1:0] != 0`.
- `q_count`  out  $clog2(DEPTH)+1  current occupancy, for debug/perf.

## Operation
- Storage: circular buffer of `DEPTH` entries of {pc, inst, adel}. Uses `wr_ptr` and `rd_ptr` ($clog2(DEPTH) bits, natural wrap) plus `count`.
  - `full` = (`count == DEPTH`).
  - `empty` = (`count == 0`).
- Push: `if_valid && !full && !flush`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
  - adel = (`if_pc[1:0] != 2'b00`).
  - When adel is set, the inst field is stored as zero.
  - Otherwise the inst field stores `if_inst`, byte-swapped per Configuration.
- Pop: `!stall[2] && !empty && !flush`. The head entry loads into the `id_*` registers with `id_valid`=1, then `rd_ptr` increments.
- Bubble: `!stall[2] && empty`. The `id_*` registers load zero and `id_valid`=0.
- Hold: `stall[2]` asserted. The `id_*` registers and `rd_ptr` keep their values. Pushes still proceed until full.
- Simultaneous push and pop: both take effect and `count` is unchanged. When full, `if_ready`=0, so no push occurs even if a pop happens that cycle; there is no full-bypass.
- Empty-queue push: there is no bypass. The word reaches `id_*` at the earliest on the next edge after it is written.
- Flush: clears `wr_ptr`, `rd_ptr`, `count` and all `id_*` outputs to zero. Any push or pop in the same cycle is discarded. Flush overrides stall.
- Priority: `rst` > `flush` > stall/pop/push.

## Timing
- Reset values: `id_pc`=0, `id_inst`=0, `id_valid`=0, `id_adel`=0, `q_count`=0. `if_ready`=1 from the first cycle after reset.
- Latency: a word pushed at edge N into an empty queue appears on `id_*` after edge N+1, provided `stall[2]`=0 at N+1. Best-case fetch-to-decode latency is therefore 2 cycles; the old block had 1.
- Throughput: one instruction per cycle in steady state.
- `if_ready` has no registered delay. Fetch must sample it in the same cycle it asserts `if_valid`.
- Reset or flush mid-burst: all queued entries are lost. Fetch restarts from the new PC supplied by `pc_reg`.
- Pointer wrap: after `DEPTH` pushes, `wr_ptr` returns to 0. Ordering is preserved across the wrap.

## Configuration
- `IF_ID_BSWAP_EN` defined: the stored inst is byte-reversed, i.e. byte i goes to byte `DATA_W/8-1-i`. For 32 bits this is {`if_inst[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`}. This matches the little-endian instruction memory.
- Undefined: `if_inst` is stored unchanged.
- Misaligned-PC zeroing and `id_adel` apply in both builds.

## Test plan
- Reset/bubble: assert `rst` 2 cycles with `if_valid`=0 → all outputs 0 and `if_ready`=1. Keep `stall`=0 → `id_valid` stays 0.
- Streaming: push `if_pc`=0x100, 0x104, 0x108 on consecutive cycles with `stall`=0 → `id_pc` shows 0x100, 0x104, 0x108 on cycles 2, 3, 4 and `q_count` ≤1.
  - With `IF_ID_BSWAP_EN`, `if_inst`=0x11223344 → `id_inst`=0x44332211.
- Fill under stall: hold `stall[2]`=1 and push 0x200..0x20C (DEPTH=4) → `if_ready`=0 and `q_count`=4. A fifth push is ignored. Release stall → 0x200..0x20C emerge in order.
- Wrap: 6 pushes with staggered stalls at DEPTH=4 → the output order equals the input order and `q_count` never exceeds 4.
- Flush: with 3 entries queued, pulse `flush` while `if_valid`=1 → next cycle `q_count`=0, `id_valid`=0, `id_pc`=0. The pushed word is dropped.
- Misaligned: push `if_pc`=0x102, `if_inst`=0xDEADBEEF → on `id_*`: `id_adel`=1, `id_inst`=0, `id_pc`=0x102.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry circular buffer between fetch and decode.
// Optional build macro IF_ID_BSWAP_EN byte-reverses stored instruction words.
module if_id_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               stall,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [DATA_W-1:0]        if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [DATA_W-1:0]        id_inst,
    output logic                     id_adel,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NB    = DATA_W / 8;

    logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
    logic [DATA_W-1:0] r_mem_inst [DEPTH];
    logic              r_mem_adel [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [DATA_W-1:0] r_id_inst;
    logic              r_id_adel;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_adel_in;
    logic [DATA_W-1:0] w_swapped;
    logic [DATA_W-1:0] w_inst_in;
    logic              w_unused_stall;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = if_valid && !w_full && !flush;
    assign w_pop     = !stall[2] && !w_empty && !flush;
    assign w_adel_in = (if_pc[1:0] != 2'b00);

    // Only the decode-stop bit of the ctrl stall vector matters here.
    assign w_unused_stall = ^{stall[5:3], stall[1:0]};

    always_comb begin
        w_swapped = if_inst;
`ifdef IF_ID_BSWAP_EN
        for (int i = 0; i < int'(NB); i++) begin
            w_swapped[8*i +: 8] = if_inst[8*(int'(NB)-1-i) +: 8];
        end
`endif
    end

    assign w_inst_in = w_adel_in ? '0 : w_swapped;

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_pc[r_wr_ptr]   <= if_pc;
            r_mem_inst[r_wr_ptr] <= w_inst_in;
            r_mem_adel[r_wr_ptr] <= w_adel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_id_valid <= 1'b0;
            r_id_pc    <= '0;
            r_id_inst  <= '0;
            r_id_adel  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (!stall[2]) begin
                if (w_empty) begin
                    r_id_valid <= 1'b0;
                    r_id_pc    <= '0;
                    r_id_inst  <= '0;
                    r_id_adel  <= 1'b0;
                end else begin
                    r_id_valid <= 1'b1;
                    r_id_pc    <= r_mem_pc[r_rd_ptr];
                    r_id_inst  <= r_mem_inst[r_rd_ptr];
                    r_id_adel  <= r_mem_adel[r_rd_ptr];
                    r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign if_ready = !w_full;
    assign id_valid = r_id_valid;
    assign id_pc    = r_id_pc;
    assign id_inst  = r_id_inst;
    assign id_adel  = r_id_adel;
    assign q_count  = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue at DEPTH=4, 32-bit PC and instruction.
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;
    logic [2:0]  q_count;

    int n_checks = 0;
    int n_errors = 0;

    if_id_queue #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_adel  (id_adel),
        .q_count  (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst);
        stall    = s ? 6'b000100 : 6'b000000;
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst;
    endtask

    logic [31:0] exp_swap;

    initial begin
`ifdef IF_ID_BSWAP_EN
        exp_swap = 32'h44332211;
`else
        exp_swap = 32'h11223344;
`endif
        rst = 1'b1;
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_pc", id_pc, 32'd0);
        check("rst_inst", id_inst, 32'd0);
        check("rst_adel", {31'd0, id_adel}, 32'd0);
        check("rst_count", {29'd0, q_count}, 32'd0);
        check("rst_ready", {31'd0, if_ready}, 32'd1);
        rst = 1'b0;
        step();
        check("bubble_valid", {31'd0, id_valid}, 32'd0);

        // Streaming: two-cycle latency, occupancy stays at most one.
        drive(1'b0, 1'b1, 32'h100, 32'h11223344);
        step();
        check("str0_count", {29'd0, q_count}, 32'd1);
        check("str0_valid", {31'd0, id_valid}, 32'd0);
        drive(1'b0, 1'b1, 32'h104, 32'h55667788);
        step();
        check("str1_pc", id_pc, 32'h100);
        check("str1_inst", id_inst, exp_swap);
        check("str1_adel", {31'd0, id_adel}, 32'd0);
        check("str1_count", {29'd0, q_count}, 32'd1);
        drive(1'b0, 1'b1, 32'h108, 32'h0);
        step();
        check("str2_pc", id_pc, 32'h104);
        check("str2_count", {29'd0, q_count}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("str3_pc", id_pc, 32'h108);
        check("str3_valid", {31'd0, id_valid}, 32'd1);
        check("str3_count", {29'd0, q_count}, 32'd0);
        step();
        check("str4_bubble", {31'd0, id_valid}, 32'd0);

        // Fill under stall, then a rejected fifth push.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            step();
            check("fill_count", {29'd0, q_count}, 32'(i + 1));
        end
        check("fill_ready", {31'd0, if_ready}, 32'd0);
        drive(1'b1, 1'b1, 32'h210, 32'hFF);
        step();
        check("fill5_count", {29'd0, q_count}, 32'd4);
        check("fill5_hold", {31'd0, id_valid}, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_pc", id_pc, 32'h200 + 32'(4 * i));
            check("drain_inst", id_inst[7:0] == 8'hA0 + 8'(i) || id_inst[31:24] == 8'hA0 + 8'(i)
                  ? 32'd1 : 32'd0, 32'd1);
            check("drain_count", {29'd0, q_count}, 32'(3 - i));
        end
        check("drain_ready", {31'd0, if_ready}, 32'd1);

        // Wrap: six pushes with staggered stalls.
        drive(1'b1, 1'b1, 32'h300, 32'h0);
        step();
        drive(1'b1, 1'b1, 32'h304, 32'h0);
        step();
        drive(1'b1, 1'b1, 32'h308, 32'h0);
        step();
        check("wrap_count3", {29'd0, q_count}, 32'd3);
        check("wrap_hold_pc", id_pc, 32'h20C);
        drive(1'b0, 1'b1, 32'h30C, 32'h0);
        step();
        check("wrap_pc0", id_pc, 32'h300);
        check("wrap_cnt_pp", {29'd0, q_count}, 32'd3);
        drive(1'b1, 1'b1, 32'h310, 32'h0);
        step();
        check("wrap_full", {29'd0, q_count}, 32'd4);
        check("wrap_hold", id_pc, 32'h300);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("wrap_pc1", id_pc, 32'h304);
        drive(1'b0, 1'b1, 32'h314, 32'h0);
        step();
        check("wrap_pc2", id_pc, 32'h308);
        check("wrap_cnt", {29'd0, q_count}, 32'd3);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("wrap_tail_pc", id_pc, 32'h30C + 32'(4 * i));
            check("wrap_tail_cnt", {29'd0, q_count}, 32'(2 - i));
        end

        // Flush with three entries queued and a push in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'h0);
            step();
        end
        check("pre_flush_cnt", {29'd0, q_count}, 32'd3);
        check("pre_flush_valid", {31'd0, id_valid}, 32'd1);
        drive(1'b1, 1'b1, 32'h40C, 32'h12345678);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", {29'd0, q_count}, 32'd0);
        check("flush_valid", {31'd0, id_valid}, 32'd0);
        check("flush_pc", id_pc, 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("flush_drop", {31'd0, id_valid}, 32'd0);

        // Misaligned fetch address.
        drive(1'b0, 1'b1, 32'h102, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("adel_flag", {31'd0, id_adel}, 32'd1);
        check("adel_inst", id_inst, 32'd0);
        check("adel_pc", id_pc, 32'h102);
        check("adel_valid", {31'd0, id_valid}, 32'd1);

        // Reset mid-burst discards queued entries.
        drive(1'b1, 1'b1, 32'h500, 32'h0);
        step();
        drive(1'b1, 1'b1, 32'h504, 32'h0);
        step();
        check("burst_cnt", {29'd0, q_count}, 32'd2);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cnt", {29'd0, q_count}, 32'd0);
        check("mid_rst_adel", {31'd0, id_adel}, 32'd0);
        step();
        check("mid_rst_bubble", {31'd0, id_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
